// File: rtl/fetch_controller.sv
// Instruction fetch front end: fetch_pc plus a 2-entry {instr, pc} queue feeding decode.
// Optional address bound check enabled by defining FETCH_BOUND_CHECK_EN.
module fetch_controller #(
  parameter logic [31:0] RESET_PC   = 32'h00000000,
  parameter int unsigned IMEM_BYTES = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rd,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  output logic        fetch_fault
);

  localparam logic [31:0] NOP_INSTR  = 32'h00000013;
  localparam logic [31:0] PC_START   = {RESET_PC[31:2], 2'b00};
  localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_BYTES);
`ifdef FETCH_BOUND_CHECK_EN
  localparam bit BOUND_CHECK = 1'b1;
`else
  localparam bit BOUND_CHECK = 1'b0;
`endif

  logic [31:0]      fetch_pc_reg, fetch_pc_next;
  logic [1:0]       count_reg, count_next;
  logic             wr_ptr_reg, wr_ptr_next;
  logic             rd_ptr_reg, rd_ptr_next;
  logic [1:0][31:0] slot_instr;
  logic [1:0][31:0] slot_pc;
  logic             out_of_range;
  logic             full;
  logic             push;
  logic             pop;

  assign out_of_range = BOUND_CHECK && (fetch_pc_reg >= IMEM_LIMIT);
  assign full         = (count_reg == 2'd2);
  assign instr_valid  = (count_reg != 2'd0);
  assign pop          = instr_valid && instr_ready && !redirect_valid;
  // A full queue still accepts a new word when the head leaves in the same cycle.
  assign push         = !redirect_valid && !out_of_range && (!full || pop);
  assign imem_addr    = fetch_pc_reg;

  always_comb begin
    fetch_pc_next = fetch_pc_reg;
    count_next    = count_reg;
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    if (redirect_valid) begin
      fetch_pc_next = {redirect_pc[31:2], 2'b00};
      count_next    = 2'd0;
      wr_ptr_next   = 1'b0;
      rd_ptr_next   = 1'b0;
    end else begin
      if (push) begin
        fetch_pc_next = fetch_pc_reg + 32'd4;
        wr_ptr_next   = ~wr_ptr_reg;
      end
      if (pop) begin
        rd_ptr_next = ~rd_ptr_reg;
      end
      case ({push, pop})
        2'b10:   count_next = count_reg + 2'd1;
        2'b01:   count_next = count_reg - 2'd1;
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_reg <= PC_START;
      count_reg    <= 2'd0;
      wr_ptr_reg   <= 1'b0;
      rd_ptr_reg   <= 1'b0;
    end else begin
      fetch_pc_reg <= fetch_pc_next;
      count_reg    <= count_next;
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
    end
  end

  // Queue payload needs no reset: count_reg alone decides what is visible.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_slot
      logic [31:0] instr_reg;
      logic [31:0] pc_reg;
      always_ff @(posedge clk) begin
        if (push && (wr_ptr_reg == 1'(gi))) begin
          instr_reg <= imem_rd;
          pc_reg    <= fetch_pc_reg;
        end
      end
      assign slot_instr[gi] = instr_reg;
      assign slot_pc[gi]    = pc_reg;
    end
  endgenerate

  assign instr    = instr_valid ? slot_instr[rd_ptr_reg] : NOP_INSTR;
  assign instr_pc = instr_valid ? slot_pc[rd_ptr_reg]    : fetch_pc_reg;

`ifdef FETCH_BOUND_CHECK_EN
  logic fault_reg;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_reg <= 1'b0;
    end else if (redirect_valid) begin
      fault_reg <= 1'b0;
    end else if (out_of_range) begin
      fault_reg <= 1'b1;
    end
  end
  assign fetch_fault = fault_reg;
`else
  assign fetch_fault = 1'b0;
`endif

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000, the byte address fetched first after reset.
REQ-002 SHALL have parameter IMEM_BYTES, default 256, the instruction memory size in bytes (64 words).
REQ-003 SHALL have one clock; reset is asynchronous and active-low; ports clk and rst_n.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 imem_addr  output  32  byte address driven to the instruction memory.
REQ-007 imem_rd  input  32  word returned combinationally by the instruction memory for imem_addr.
REQ-008 redirect_valid  input  1  branch/jump redirect request.
REQ-009 redirect_pc  input  32  redirect target byte address.
REQ-010 instr_valid  output  1  queue head holds a valid instruction.
REQ-011 instr  output  32  queue head instruction word.
REQ-012 instr_pc  output  32  byte address of the queue head instruction.
REQ-013 instr_ready  input  1  decode stage accepts the head this cycle.
REQ-014 fetch_fault  output  1  fetch stopped on an out-of-range address.

Function
REQ-015 SHALL hold fetch_pc and a 2-entry FIFO of {instr, pc} pairs; imem_addr SHALL equal fetch_pc at all times.
REQ-016 Push condition: no redirect, not halted by fault, and FIFO not full or a pop occurs this cycle; on push, capture {imem_rd, fetch_pc} and fetch_pc <= fetch_pc + 4.
REQ-017 Pop condition: instr_valid && instr_ready; head advances at the clock edge.
REQ-018 Simultaneous push and pop SHALL be legal at every occupancy, including full (count unchanged).
REQ-019 instr_valid SHALL be 1 iff count > 0; when count = 0, instr SHALL be 32'h00000013 (NOP) and instr_pc SHALL be fetch_pc.
REQ-020 Latency: a word pushed at edge N SHALL be presented at instr/instr_valid after edge N (combinational from FIFO state, not imem_rd).
REQ-021 Redirect SHALL have priority over push and pop: FIFO emptied, fetch_pc <= {redirect_pc[31:2], 2'b00}, no push, pop ignored, fetch_fault cleared.
REQ-022 After a redirect at edge N, instr_valid SHALL be 0 for the cycle following edge N and the target instruction SHALL be valid after edge N+1.
REQ-023 fetch_pc increments SHALL wrap 32'hFFFFFFFC -> 32'h00000000.
REQ-024 FIFO read/write pointers SHALL wrap modulo 2; count range 0..2.

Reset
REQ-025 On rst_n = 0 (asynchronous): fetch_pc = RESET_PC with bits [1:0] forced to 0, count = 0, pointers = 0, fetch_fault = 0, instr_valid = 0, instr = 32'h00000013, instr_pc = RESET_PC.
REQ-026 Reset asserted mid-operation SHALL discard all queued instructions; the first push after release SHALL occur on the first rising edge with rst_n = 1.

Configuration
REQ-027 Macro FETCH_BOUND_CHECK_EN defined: when fetch_pc >= IMEM_BYTES, no push occurs, fetch_fault SHALL be 1 from the next edge until a redirect or reset; queued entries still drain.
REQ-028 Macro FETCH_BOUND_CHECK_EN undefined: no bound check, fetch_fault SHALL be tied to 0, fetch continues past IMEM_BYTES.

Verification
REQ-029 Reset release, instr_ready = 1, memory word[k] = k: after edges 1,2,3 the bench SHALL see instr = 0,1,2 with instr_pc = 0,4,8 and instr_valid = 1 each cycle.
REQ-030 instr_ready = 0 for 5 cycles after reset: count saturates at 2, fetch_pc = 8 stays constant, instr = word[0]; ready = 1 then yields 0,1,2 in consecutive cycles.
REQ-031 FIFO full with instr_ready = 1 on the same cycle: push and pop both occur, count remains 2, fetch_pc advances by 4.
REQ-032 redirect_valid with redirect_pc = 32'h0000002E while FIFO full and ready = 1: next cycle instr_valid = 0; following cycle instr_pc = 32'h0000002C, instr = word[11].
REQ-033 With FETCH_BOUND_CHECK_EN, redirect to 32'h000000F8: pushes at F8 and FC, fetch_fault = 1 after fetch_pc reaches 32'h00000100, no further pushes; redirect to 0 clears fault. Without the macro, fetch_fault remains 0 and instr_pc 32'h00000100 appears.
REQ-034 rst_n asserted asynchronously between edges while count = 2: instr_valid drops to 0 immediately without a clock edge, then fetch restarts at RESET_PC.
